// File: rtl/sw_pkg.sv
// Shared definitions for the batched Smith-Waterman top controller.
//   - default width constants (V/E/F, match, alpha/beta, target size)
//   - controller FSM state encoding
//   - power-on values of the processed scoring parameters
//   - neg_ext: zero-extend a penalty magnitude and negate it (two's complement)
package sw_pkg;

  localparam int VEF_W   = 10;
  localparam int MATCH_W = 4;
  localparam int AB_W    = 8;
  localparam int TSIZE_W = 10;

  typedef enum logic [1:0] {IDLE, SETT, CALC, DRAIN} state_t;

  // Values the processed parameters take out of reset (truncated to port width).
  localparam int POST_MATCH_RST    = 6;
  localparam int POST_MISMATCH_RST = -1;
  localparam int POST_ALPHA_RST    = -2;
  localparam int POST_BETA_RST     = -1;

  // Caller zero-extends the magnitude into 32 bits and truncates the result,
  // so a magnitude of 0 maps to 0 and the wrap is modulo the caller's width.
  function automatic logic [31:0] neg_ext(input logic [31:0] mag);
    return ~mag + 32'd1;
  endfunction

endpackage

// File: rtl/sw_ch_arbiter.sv
// Lowest-index-first fixed-priority selector.
//   req : request vector
//   gnt : one-hot grant (lowest set bit of req)
//   vld : any request present
//   idx : binary index of the granted bit (0 when vld is low)
module sw_ch_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic             vld,
  output logic [IDX_W-1:0] idx
);

  // Isolate the lowest set bit.
  assign gnt = req & (~req + 1'b1);
  assign vld = |req;

  always_comb begin
    idx = '0;
    for (int i = N-1; i >= 0; i--)
      if (req[i]) idx = IDX_W'(i);
  end

endmodule

// File: rtl/sw_batch_top_ctrl.sv
// Batched Smith-Waterman top-level controller.
// Takes user commands (target load, batch run), keeps the processed scoring
// parameters, dispatches batch jobs over NUM_CH PE-array channels, and returns
// per-job scores one per cycle tagged with job id and channel.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   i_set_t/i_start_cal/i_batch_len user commands (registered before use)
//   i_param_valid, i_match, i_mismatch, i_minus_alpha, i_minus_beta
//                                   parameter write (dropped while in CALC)
//   o_post_*                        processed scoring parameters
//   o_busy/o_reject/o_done          status; o_reject and o_done are 1-cycle pulses
//   o_valid/o_result/o_result_job/o_result_ch   result stream
//   o_start_read_t, i_sram_busy, i_t_size        SRAM controller side
//   o_ch_start, i_ch_busy, i_ch_valid, i_ch_result  PE-array channel side
// Optional build macro SW_BATCH_MAX_EN adds o_batch_max / o_batch_max_job:
// signed maximum of the batch's scores and its job id, held after o_done.
module sw_batch_top_ctrl #(
  parameter int NUM_CH  = 2,
  parameter int VEF_W   = sw_pkg::VEF_W,
  parameter int MATCH_W = sw_pkg::MATCH_W,
  parameter int AB_W    = sw_pkg::AB_W,
  parameter int TSIZE_W = sw_pkg::TSIZE_W,
  parameter int BATCH_W = 8,
  parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_set_t,
  input  logic                    i_start_cal,
  input  logic [BATCH_W-1:0]      i_batch_len,
  input  logic                    i_param_valid,
  input  logic [MATCH_W-1:0]      i_match,
  input  logic [MATCH_W-1:0]      i_mismatch,
  input  logic [AB_W-1:0]         i_minus_alpha,
  input  logic [AB_W-1:0]         i_minus_beta,
  output logic                    o_busy,
  output logic                    o_reject,
  output logic                    o_valid,
  output logic [VEF_W-1:0]        o_result,
  output logic [BATCH_W-1:0]      o_result_job,
  output logic [CH_W-1:0]         o_result_ch,
  output logic                    o_done,
  output logic [MATCH_W-1:0]      o_post_match,
  output logic [VEF_W-1:0]        o_post_mismatch,
  output logic [VEF_W-1:0]        o_post_alpha,
  output logic [VEF_W-1:0]        o_post_beta,
  output logic                    o_start_read_t,
  input  logic                    i_sram_busy,
  input  logic [TSIZE_W-1:0]      i_t_size,
  output logic [NUM_CH-1:0]       o_ch_start,
  input  logic [NUM_CH-1:0]       i_ch_busy,
  input  logic [NUM_CH-1:0]       i_ch_valid,
  input  logic [NUM_CH*VEF_W-1:0] i_ch_result
`ifdef SW_BATCH_MAX_EN
  ,
  output logic [VEF_W-1:0]        o_batch_max,
  output logic [BATCH_W-1:0]      o_batch_max_job
`endif
);

  import sw_pkg::*;

  // ---- user input register stage ----
  logic               r_set_t, r_start_cal, r_param_valid;
  logic [BATCH_W-1:0] r_batch_len;
  logic [MATCH_W-1:0] r_match, r_mismatch;
  logic [AB_W-1:0]    r_alpha, r_beta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_set_t       <= 1'b0;
      r_start_cal   <= 1'b0;
      r_param_valid <= 1'b0;
      r_batch_len   <= '0;
      r_match       <= '0;
      r_mismatch    <= '0;
      r_alpha       <= '0;
      r_beta        <= '0;
    end else begin
      r_set_t       <= i_set_t;
      r_start_cal   <= i_start_cal;
      r_param_valid <= i_param_valid;
      r_batch_len   <= i_batch_len;
      r_match       <= i_match;
      r_mismatch    <= i_mismatch;
      r_alpha       <= i_minus_alpha;
      r_beta        <= i_minus_beta;
    end
  end

  // ---- controller state ----
  state_t             state, state_nxt;
  logic [BATCH_W-1:0] batch_len, issued, collected;
  logic [NUM_CH-1:0]  pending, hold;
  logic [NUM_CH-1:0][VEF_W-1:0]   hold_data;
  logic [NUM_CH-1:0][BATCH_W-1:0] ch_job;

  logic start_ok, start_rd_nxt, reject_nxt, done_nxt, calc_entry;
  assign start_ok = r_start_cal && (i_t_size != '0) && (r_batch_len != '0);

  // ---- dispatch / emission selection ----
  logic [NUM_CH-1:0] disp_req, disp_gnt, emit_req, emit_gnt, cap;
  logic              disp_vld, emit_vld;
  logic [CH_W-1:0]   disp_idx, emit_idx;

  assign disp_req = (state == CALC && issued < batch_len) ? (~i_ch_busy & ~pending) : '0;
  assign emit_req = (state == CALC) ? hold : '0;
  // A channel's score is taken once; further strobes before emission are ignored.
  assign cap      = (state == CALC) ? (i_ch_valid & pending & ~hold) : '0;

  sw_ch_arbiter #(.N(NUM_CH), .IDX_W(CH_W)) u_disp_arb (
    .req(disp_req), .gnt(disp_gnt), .vld(disp_vld), .idx(disp_idx)
  );

  sw_ch_arbiter #(.N(NUM_CH), .IDX_W(CH_W)) u_emit_arb (
    .req(emit_req), .gnt(emit_gnt), .vld(emit_vld), .idx(emit_idx)
  );

  // ---- FSM next state and pulse outputs ----
  always_comb begin
    state_nxt    = state;
    start_rd_nxt = 1'b0;
    reject_nxt   = 1'b0;
    done_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (r_set_t) begin
          state_nxt    = SETT;
          start_rd_nxt = 1'b1;
        end else if (start_ok) begin
          state_nxt = CALC;
        end else if (r_start_cal) begin
          reject_nxt = 1'b1;
        end
      end
      // o_start_read_t is still high on the first SETT cycle, which gives
      // the SRAM controller a cycle to raise i_sram_busy.
      SETT:  if (!i_sram_busy && !o_start_read_t) state_nxt = IDLE;
      CALC:  if (collected == batch_len) state_nxt = DRAIN;
      DRAIN: begin
        if (i_ch_busy == '0 && !i_sram_busy) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign calc_entry = (state == IDLE) && (state_nxt == CALC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      batch_len      <= '0;
      issued         <= '0;
      collected      <= '0;
      o_busy         <= 1'b0;
      o_start_read_t <= 1'b0;
      o_reject       <= 1'b0;
      o_done         <= 1'b0;
    end else begin
      state          <= state_nxt;
      o_busy         <= (state_nxt != IDLE);
      o_start_read_t <= start_rd_nxt;
      o_reject       <= reject_nxt;
      o_done         <= done_nxt;
      if (calc_entry) begin
        batch_len <= r_batch_len;
        issued    <= '0;
        collected <= '0;
      end else begin
        if (disp_vld) issued    <= issued + 1'b1;
        if (emit_vld) collected <= collected + 1'b1;
      end
    end
  end

  // ---- per-channel bookkeeping and result stream ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending      <= '0;
      hold         <= '0;
      hold_data    <= '0;
      ch_job       <= '0;
      o_ch_start   <= '0;
      o_valid      <= 1'b0;
      o_result     <= '0;
      o_result_job <= '0;
      o_result_ch  <= '0;
    end else begin
      o_ch_start <= disp_gnt;
      o_valid    <= emit_vld;
      // dispatch targets non-pending channels, emission only held (so pending)
      // ones: set and clear never hit the same bit in one cycle.
      pending    <= (pending | disp_gnt) & ~emit_gnt;
      hold       <= (hold | cap) & ~emit_gnt;
      for (int k = 0; k < NUM_CH; k++) begin
        if (cap[k])      hold_data[k] <= i_ch_result[k*VEF_W +: VEF_W];
        if (disp_gnt[k]) ch_job[k]    <= issued;
      end
      if (emit_vld) begin
        o_result     <= hold_data[emit_idx];
        o_result_job <= ch_job[emit_idx];
        o_result_ch  <= emit_idx;
      end
    end
  end

  // ---- processed scoring parameters ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_post_match    <= MATCH_W'(POST_MATCH_RST);
      o_post_mismatch <= VEF_W'(POST_MISMATCH_RST);
      o_post_alpha    <= VEF_W'(POST_ALPHA_RST);
      o_post_beta     <= VEF_W'(POST_BETA_RST);
    end else if (r_param_valid && state != CALC) begin
      o_post_match    <= r_match;
      o_post_mismatch <= VEF_W'(neg_ext(32'(r_mismatch)));
      o_post_alpha    <= VEF_W'(neg_ext(32'(r_alpha)));
      o_post_beta     <= VEF_W'(neg_ext(32'(r_beta)));
    end
  end

`ifdef SW_BATCH_MAX_EN
  // Running signed max of emitted scores; equal scores keep the lower job id.
  logic max_have;
  logic signed [VEF_W-1:0] emit_score;
  assign emit_score = hold_data[emit_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_have        <= 1'b0;
      o_batch_max     <= '0;
      o_batch_max_job <= '0;
    end else if (calc_entry) begin
      max_have        <= 1'b0;
      o_batch_max     <= '0;
      o_batch_max_job <= '0;
    end else if (emit_vld) begin
      max_have <= 1'b1;
      if (!max_have || emit_score > $signed(o_batch_max) ||
          (emit_score == $signed(o_batch_max) && ch_job[emit_idx] < o_batch_max_job)) begin
        o_batch_max     <= emit_score;
        o_batch_max_job <= ch_job[emit_idx];
      end
    end
  end
`endif

endmodule

// File: tb/tb_sw_batch_top_ctrl.sv
// Directed bench for sw_batch_top_ctrl: channel responders model the PE arrays
// and push the expected tagged result to a scoreboard when they return a score;
// the output monitor pops and compares on every o_valid.
module tb_sw_batch_top_ctrl;

  localparam int NUM_CH = 2;
  localparam int VEF_W  = 10;
  localparam int BW     = 8;

  logic clk = 1'b0, rst_n = 1'b0;
  logic i_set_t = 0, i_start_cal = 0, i_param_valid = 0, i_sram_busy = 0;
  logic [BW-1:0] i_batch_len = '0;
  logic [3:0] i_match = '0, i_mismatch = '0;
  logic [7:0] i_minus_alpha = '0, i_minus_beta = '0;
  logic [9:0] i_t_size = '0;
  logic [NUM_CH-1:0] i_ch_busy = '0, i_ch_valid = '0;
  logic [NUM_CH*VEF_W-1:0] i_ch_result = '0;

  logic o_busy, o_reject, o_valid, o_done, o_start_read_t;
  logic [VEF_W-1:0] o_result, o_post_mismatch, o_post_alpha, o_post_beta;
  logic [BW-1:0] o_result_job;
  logic [0:0] o_result_ch;
  logic [3:0] o_post_match;
  logic [NUM_CH-1:0] o_ch_start;
`ifdef SW_BATCH_MAX_EN
  logic [VEF_W-1:0] o_batch_max;
  logic [BW-1:0] o_batch_max_job;
`endif

  sw_batch_top_ctrl #(.NUM_CH(NUM_CH)) dut (
    .clk(clk), .rst_n(rst_n), .i_set_t(i_set_t), .i_start_cal(i_start_cal),
    .i_batch_len(i_batch_len), .i_param_valid(i_param_valid), .i_match(i_match),
    .i_mismatch(i_mismatch), .i_minus_alpha(i_minus_alpha), .i_minus_beta(i_minus_beta),
    .o_busy(o_busy), .o_reject(o_reject), .o_valid(o_valid), .o_result(o_result),
    .o_result_job(o_result_job), .o_result_ch(o_result_ch), .o_done(o_done),
    .o_post_match(o_post_match), .o_post_mismatch(o_post_mismatch),
    .o_post_alpha(o_post_alpha), .o_post_beta(o_post_beta),
    .o_start_read_t(o_start_read_t), .i_sram_busy(i_sram_busy), .i_t_size(i_t_size),
    .o_ch_start(o_ch_start), .i_ch_busy(i_ch_busy), .i_ch_valid(i_ch_valid),
    .i_ch_result(i_ch_result)
`ifdef SW_BATCH_MAX_EN
    , .o_batch_max(o_batch_max), .o_batch_max_job(o_batch_max_job)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct { int res; int job; int ch; } exp_t;
  exp_t sb[$];

  int scores[8];
  int lat[NUM_CH];
  int cnt[NUM_CH], job_of[NUM_CH];
  bit act[NUM_CH];
  int starts = 0, cyc = 0;
  int n_rd = 0, n_rej = 0, n_done = 0, n_start = 0, n_valid = 0;
  int vcyc[$];
  logic [31:0] seen = '0;

  // Output monitor followed by channel responder models.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      for (int k = 0; k < NUM_CH; k++) act[k] = 0;
      i_ch_busy  = '0;
      i_ch_valid = '0;
    end else begin
      if (o_start_read_t) n_rd++;
      if (o_reject)       n_rej++;
      if (o_done)         n_done++;
      if (o_ch_start != '0) begin
        n_start += $countones(o_ch_start);
        check("ch_start_onehot", 32'($onehot(o_ch_start)), 1);
      end
      if (o_valid) begin
        n_valid++;
        vcyc.push_back(cyc);
        check("result_expected", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("result_score", 32'(o_result), 32'(e.res));
          check("result_job", 32'(o_result_job), 32'(e.job));
          check("result_ch", 32'(o_result_ch), 32'(e.ch));
          check("job_once", 32'(seen[o_result_job[4:0]]), 0);
          seen[o_result_job[4:0]] = 1'b1;
        end
      end
      i_ch_valid = '0;
      for (int k = 0; k < NUM_CH; k++) begin
        if (act[k]) begin
          if (cnt[k] == 0) begin
            exp_t e;
            i_ch_valid[k] = 1'b1;
            i_ch_result[k*VEF_W +: VEF_W] = VEF_W'(scores[job_of[k]]);
            e.res = scores[job_of[k]]; e.job = job_of[k]; e.ch = k;
            sb.push_back(e);
            act[k] = 0;
            i_ch_busy[k] = 1'b0;
          end else cnt[k]--;
        end
      end
      for (int k = 0; k < NUM_CH; k++) begin
        if (o_ch_start[k]) begin
          act[k] = 1; cnt[k] = lat[k]; job_of[k] = starts; starts++;
          i_ch_busy[k] = 1'b1;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic pulse_start();
    i_start_cal = 1; tick(1); i_start_cal = 0;
  endtask

  task automatic wait_done(input int lim, input string tag);
    int d0, k;
    d0 = n_done; k = 0;
    while (n_done == d0 && k < lim) begin tick(1); k++; end
    check(tag, 32'(n_done != d0), 1);
  endtask

  initial begin
    // ---- reset values ----
    tick(3);
    check("rst_match", 32'(o_post_match), 32'h6);
    check("rst_mismatch", 32'(o_post_mismatch), 32'h3FF);
    check("rst_alpha", 32'(o_post_alpha), 32'h3FE);
    check("rst_beta", 32'(o_post_beta), 32'h3FF);
    check("rst_busy", 32'(o_busy), 0);
    check("rst_valid_done", 32'({o_valid, o_done, o_ch_start}), 0);
    rst_n = 1; tick(2);

    // ---- parameter write in IDLE ----
    i_match = 9; i_mismatch = 3; i_minus_alpha = 5; i_minus_beta = 0; i_param_valid = 1;
    tick(1); i_param_valid = 0; tick(2);
    check("par_match", 32'(o_post_match), 32'h9);
    check("par_mismatch", 32'(o_post_mismatch), 32'h3FD);
    check("par_alpha", 32'(o_post_alpha), 32'h3FB);
    check("par_beta", 32'(o_post_beta), 32'h000);

    // ---- target load ----
    i_sram_busy = 1; i_set_t = 1; tick(1); i_set_t = 0; tick(1);
    check("sett_busy_rise", 32'(o_busy), 1);
    check("sett_rd_pulse", 32'(o_start_read_t), 1);
    tick(10);
    check("sett_busy_hold", 32'(o_busy), 1);
    i_sram_busy = 0; tick(3);
    check("sett_rd_count", 32'(n_rd), 1);
    check("sett_idle", 32'(o_busy), 0);

    // ---- rejects ----
    i_t_size = 0; i_batch_len = 5; pulse_start(); tick(3);
    check("rej_tsize", 32'(n_rej), 1);
    check("rej_no_start", 32'(n_start), 0);
    i_t_size = 4; i_batch_len = 0; pulse_start(); tick(3);
    check("rej_batch0", 32'(n_rej), 2);
    check("rej_busy", 32'(o_busy), 0);

    // ---- 5-job batch over 2 channels, param write dropped in CALC ----
    scores[0] = 7; scores[1] = 3; scores[2] = 9; scores[3] = 1; scores[4] = 4;
    lat[0] = 3; lat[1] = 3; starts = 0; seen = '0; n_valid = 0; n_start = 0;
    i_batch_len = 5; pulse_start(); tick(3);
    check("calc_busy", 32'(o_busy), 1);
    i_mismatch = 7; i_minus_alpha = 1; i_minus_beta = 2; i_match = 1; i_param_valid = 1;
    tick(1); i_param_valid = 0; tick(3);
    check("calc_par_match", 32'(o_post_match), 32'h9);
    check("calc_par_mismatch", 32'(o_post_mismatch), 32'h3FD);
    check("calc_par_alpha", 32'(o_post_alpha), 32'h3FB);
    wait_done(300, "batch_done_timeout");
    check("batch_valid_cnt", 32'(n_valid), 5);
    check("batch_start_cnt", 32'(n_start), 5);
    check("batch_jobs_seen", seen, 32'h1F);
    check("batch_sb_empty", 32'(sb.size()), 0);
    check("batch_busy_fall", 32'(o_busy), 0);
`ifdef SW_BATCH_MAX_EN
    check("batch_max", 32'(o_batch_max), 9);
    check("batch_max_job", 32'(o_batch_max_job), 2);
`endif
    tick(2);
    check("done_once", 32'(n_done), 1);

    // ---- simultaneous channel valids ----
    scores[0] = 12; scores[1] = 34;
    lat[0] = 4; lat[1] = 3; starts = 0; seen = '0; n_valid = 0; vcyc.delete();
    i_batch_len = 2; pulse_start();
    wait_done(200, "simul_done_timeout");
    check("simul_valid_cnt", 32'(n_valid), 2);
    if (vcyc.size() == 2) check("simul_back_to_back", 32'(vcyc[1] - vcyc[0]), 1);
    check("simul_sb_empty", 32'(sb.size()), 0);

    // ---- reset mid-batch ----
    lat[0] = 20; lat[1] = 20; starts = 0; seen = '0;
    i_batch_len = 5; pulse_start(); tick(5);
    check("mid_busy", 32'(o_busy), 1);
    rst_n = 0; tick(1);
    check("mid_rst_busy", 32'(o_busy), 0);
    check("mid_rst_outs", 32'({o_valid, o_done, o_ch_start, o_reject, o_start_read_t}), 0);
    check("mid_rst_match", 32'(o_post_match), 32'h6);
    check("mid_rst_alpha", 32'(o_post_alpha), 32'h3FE);
    sb.delete();
    rst_n = 1; tick(40);
    check("mid_no_done", 32'(n_done), 2);
    check("mid_idle", 32'(o_busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sw_batch_top_ctrl.md
Name: sw_batch_top_ctrl

Overview:
- Parametrised successor of the single-engine Smith-Waterman top-level controller.
- Owns the user command FSM, the scoring-parameter registers and dispatch of a batch of query jobs across NUM_CH independent PE-array channels.
- Collects per-channel scores and returns them one per cycle, tagged with job id and channel, then drains before reporting done.
- Sits between the user interface and the SRAM controller, data processors and PE-array channels.

Parameters:
- NUM_CH, 2, number of PE-array channels (1..8).
- VEF_W, 10, V/E/F score width.
- MATCH_W, 4, match/mismatch input width.
- AB_W, 8, alpha/beta penalty input width.
- TSIZE_W, 10, stored target-length width.
- BATCH_W, 8, job counter and job id width.
- CH_W, $clog2(NUM_CH) min 1, channel index width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- i_set_t  in  1  request target load
- i_start_cal  in  1  request batch run
- i_batch_len  in  BATCH_W  number of jobs in the batch
- i_param_valid  in  1  parameter write strobe
- i_match  in  MATCH_W  match score
- i_mismatch  in  MATCH_W  mismatch penalty magnitude
- i_minus_alpha  in  AB_W  gap-open penalty magnitude
- i_minus_beta  in  AB_W  gap-extend penalty magnitude
- o_busy  out  1  controller busy
- o_reject  out  1  start refused, 1-cycle pulse
- o_valid  out  1  result strobe
- o_result  out  VEF_W  job score
- o_result_job  out  BATCH_W  job id of o_result
- o_result_ch  out  CH_W  channel that produced o_result
- o_done  out  1  batch complete, 1-cycle pulse
- o_post_match  out  MATCH_W  processed match score
- o_post_mismatch  out  VEF_W  processed mismatch score
- o_post_alpha  out  VEF_W  processed gap-open score
- o_post_beta  out  VEF_W  processed gap-extend score
- o_start_read_t  out  1  SRAM target-load start pulse
- i_sram_busy  in  1  SRAM controller busy
- i_t_size  in  TSIZE_W  stored target length
- o_ch_start  out  NUM_CH  per-channel start pulse
- i_ch_busy  in  NUM_CH  per-channel busy
- i_ch_valid  in  NUM_CH  per-channel result strobe
- i_ch_result  in  NUM_CH*VEF_W  per-channel score, channel k at bits [k*VEF_W +: VEF_W]

Behaviour:
- Input registering: all user inputs pass through one register stage; the FSM acts only on the registered copies.
- Reset values:
  - state IDLE; all outputs 0 except the parameter registers below.
  - o_post_match=6; o_post_mismatch=all-ones (-1); o_post_alpha=-2; o_post_beta=-1.
  - Per-channel pending flags cleared. Reset mid-batch aborts the batch with no o_done.
- Parameters:
  - A registered i_param_valid updates the parameter registers one cycle later, in any state except CALC. In CALC it is dropped.
  - o_post_match = i_match.
  - o_post_mismatch, o_post_alpha, o_post_beta = two's-complement negation of the zero-extended input, modulo 2^VEF_W. A magnitude of 0 yields 0.
- FSM states: IDLE, SETT, CALC, DRAIN.
- IDLE:
  - set_t wins over start_cal: go to SETT and pulse o_start_read_t for 1 cycle.
  - Else start_cal with i_t_size!=0 and batch_len!=0: latch batch_len, clear the issued and collected counters, go to CALC.
  - Else start_cal with i_t_size==0 or batch_len==0: pulse o_reject, stay in IDLE.
- SETT: go to IDLE when ~i_sram_busy and o_start_read_t==0.
- CALC dispatch:
  - While issued<batch_len, each cycle select the lowest-index channel with ~i_ch_busy and ~pending.
  - Pulse its o_ch_start bit (registered), set pending, record job id = issued in that channel's job register, then issued++.
  - At most one start per cycle.
- CALC collect:
  - i_ch_valid on a pending channel latches the score into that channel's holding register and sets a hold flag.
  - Each cycle the lowest-index held channel is emitted: o_valid=1 with o_result, o_result_job and o_result_ch, registered so they appear the cycle after selection. Its hold and pending flags clear and collected++.
  - Simultaneous valids on several channels serialise, lowest index first.
  - A channel is not restarted until its result has been emitted.
  - i_ch_valid on a non-pending channel is ignored.
- CALC exit: when collected==batch_len, go to DRAIN.
- DRAIN: when i_ch_busy==0 and ~i_sram_busy, go to IDLE and pulse o_done the same cycle.
- o_busy: register of (next state != IDLE). It rises 2 cycles after the user pulse and falls with o_done.
- User commands arriving outside IDLE are ignored.

Optional Feature:
- Macro: SW_BATCH_MAX_EN.
- When defined:
  - Adds outputs o_batch_max (VEF_W) and o_batch_max_job (BATCH_W).
  - A running signed maximum of the emitted scores is cleared on CALC entry; ties keep the earlier job.
  - Both outputs are valid and held from the o_done cycle until the next CALC entry.
- When undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package sw_pkg:
  - width constants VEF_W, MATCH_W, AB_W, TSIZE_W.
  - FSM state encoding.
  - parameter reset constants.
  - a negate-and-extend function.
- One natural sub-module, sw_ch_arbiter: lowest-index-first priority selection, instantiated twice (dispatch and result emission).

Test Plan:
- Reset, then read the parameter outputs -> match=6, mismatch=0x3FF, alpha=0x3FE, beta=0x3FF; o_busy=0.
- param_valid with mismatch=3, alpha=5, beta=0 in IDLE -> 0x3FD, 0x3FB, 0x000; repeat during CALC -> values unchanged.
- set_t then i_sram_busy high for 10 cycles -> one o_start_read_t pulse, o_busy high, return to IDLE after i_sram_busy falls.
- t_size=0 with start_cal -> o_reject pulse, no o_ch_start; t_size=4 with batch_len=0 -> o_reject.
- NUM_CH=2, batch_len=5, channels return scores 7,3,9,1,4 -> five o_valid strobes with jobs 0..4 each emitted exactly once, then o_done after DRAIN; with SW_BATCH_MAX_EN, o_batch_max=9 and o_batch_max_job=2.
- Both channels assert i_ch_valid in the same cycle -> ch0 emitted, ch1 emitted the next cycle, no loss; reset asserted mid-CALC -> all outputs at reset values and no o_done.
